// File: rtl/ram_clr.sv
// ============================================================================
//  Module      : ram_clr
//  Description : Single-port synchronous RAM with a registered read port and
//                a sequential zero-fill clear engine. Optional build macro
//                RAM_CLR_WRITE_FIRST_EN selects write-first read behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_clr #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

`ifdef RAM_CLR_WRITE_FIRST_EN
    localparam bit WRITE_FIRST = 1'b1;
`else
    localparam bit WRITE_FIRST = 1'b0;
`endif

    // One extra bit so the bound check still works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;

    logic              addr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    logic [WIDTH-1:0]  mem [DEPTH];

    assign addr_ok = ({1'b0, address} < DEPTH_EXT);
    assign busy    = (state == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        mem_we     = 1'b0;
        mem_waddr  = address;
        mem_wdata  = in;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdata = '0;
                if (ptr == LAST_PTR) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                end
            end
            IDLE: begin
                mem_we = load && addr_ok;
                // A load coinciding with clear is committed and then swept.
                if (clear) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if ((state == CLEAR) || !addr_ok) begin
            out <= '0;
        end else if (WRITE_FIRST && load) begin
            out <= in;
        end else begin
            out <= mem[address];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_clr.sv
// ============================================================================
//  Module      : tb_ram_clr
//  Description : Self-checking bench for ram_clr against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_ram_clr;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 20;

`ifdef RAM_CLR_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  din;
    logic              clear;
    logic [WIDTH-1:0]  out;
    logic              busy;

    ram_clr #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .address (address),
        .in      (din),
        .clear   (clear),
        .out     (out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Reference model: word array, remaining sweep edges, expected read data.
    logic [WIDTH-1:0] mem_m [DEPTH];
    int               busy_left;
    logic [WIDTH-1:0] exp_out;

    int vectors;
    int miscompares;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_wipe();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        busy_left = DEPTH;
    endtask

    task automatic step(input logic ld, input logic [ADDR_W-1:0] a,
                        input logic [WIDTH-1:0] d, input logic cl);
        logic [WIDTH-1:0] old;
        load    = ld;
        address = a;
        din     = d;
        clear   = cl;
        @(posedge clk);
        if (!reset) begin
            if (busy_left > 0) begin
                busy_left--;
                exp_out = '0;
            end else begin
                old = (a < DEPTH) ? mem_m[a] : '0;
                if (ld && (a < DEPTH)) mem_m[a] = d;
                exp_out = (WF && ld && (a < DEPTH)) ? d : old;
                if (cl) model_wipe();
            end
        end
        #0.5;
        check_val("out", 32'(out), 32'(exp_out));
        check_val("busy", 32'(busy), 32'(busy_left > 0));
    endtask

    task automatic do_reset(input int hold_edges);
        reset = 1'b1;
        #0.2;
        model_wipe();
        exp_out = '0;
        check_val("rst_out", 32'(out), 32'(exp_out));
        check_val("rst_busy", 32'(busy), 32'(1));
        repeat (hold_edges) @(posedge clk);
        #0.5;
        reset = 1'b0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) step(1'b0, ADDR_W'(i), '0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        load        = 1'b0;
        address     = '0;
        din         = '0;
        clear       = 1'b0;
        exp_out     = '0;
        busy_left   = DEPTH;
        #0.3;

        // Power-on sweep, then every word reads zero.
        do_reset(2);
        run_idle(DEPTH);
        read_all();

        // Write then read back.
        step(1'b1, 5'd3, 16'h00AB, 1'b0);
        step(1'b0, 5'd3, 16'h0000, 1'b0);
        step(1'b0, 5'd3, 16'h0000, 1'b0);

        // Same-address write and read ordering.
        step(1'b1, 5'd5, 16'h1234, 1'b0);
        step(1'b0, 5'd5, 16'h0000, 1'b0);

        // Out-of-range write: no effect, no aliasing.
        step(1'b1, 5'd25, 16'hFFFF, 1'b0);
        step(1'b1, 5'd31, 16'hFFFF, 1'b0);
        read_all();

        // Fill, clear, load during busy ignored, all zero afterwards.
        for (int i = 0; i < DEPTH; i++) step(1'b1, ADDR_W'(i), 16'(i + 1), 1'b0);
        read_all();
        step(1'b0, 5'd0, 16'h0000, 1'b1);
        step(1'b1, 5'd4, 16'hBEEF, 1'b1);
        run_idle(DEPTH);
        read_all();

        // Reset in the middle of a sweep restarts it.
        for (int i = 0; i < DEPTH; i++) step(1'b1, ADDR_W'(i), 16'hA500 + 16'(i), 1'b0);
        step(1'b0, 5'd0, 16'h0000, 1'b1);
        run_idle(7);
        do_reset(1);
        run_idle(DEPTH + 2);
        read_all();

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                do_reset(int'($urandom_range(0, 2)));
            end else begin
                step(1'($urandom_range(0, 1)),
                     ADDR_W'($urandom_range(0, 31)),
                     16'($urandom),
                     (r < 4));
            end
        end
        run_idle(DEPTH + 2);
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
